// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the five-stage pipeline control logic.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Execute-stage operand forwarding select for one source operand.
module forward_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_regwrite_m,
  input  logic       i_regwrite_w,
  output logic [1:0] o_fwd
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_regwrite_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs);
  assign w_hit_w = i_regwrite_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs);

  // Memory stage holds the younger result, so it wins over Writeback.
  always_comb begin
    o_fwd = FWD_RF;
    if (w_hit_m)      o_fwd = FWD_MEM;
    else if (w_hit_w) o_fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forward controller with post-reset bubbles,
// memory wait-state timeout detection and saturating perf counters.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int INIT_BUBBLES = 4,
  parameter int WAIT_MAX     = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_bubble;
  logic [WW-1:0]   r_wait;
  logic            r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic            w_init;
  logic            w_load_use;
  logic            w_br_flush;

  assign w_init     = (r_state == ST_INIT);
  assign w_load_use = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_br_flush = !w_init && MemReadyM && PCSrcE;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (w_init) begin
      StallF = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (!MemReadyM) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:    if (r_bubble == 4'd0) w_state_nxt = ST_RUN;
      ST_RUN,
      ST_MEMWAIT: w_state_nxt = MemReadyM ? ST_RUN : ST_MEMWAIT;
      default:    w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_bubble    <= 4'(INIT_BUBBLES - 1);
      r_wait      <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_init && r_bubble != 4'd0) r_bubble <= r_bubble - 4'd1;
      // Wait counter saturates at WAIT_MAX; the flag is set on the edge it gets there.
      if (!w_init) begin
        if (MemReadyM) begin
          r_wait <= '0;
        end else if (r_wait != WW'(WAIT_MAX)) begin
          r_wait <= r_wait + 1'b1;
          if (r_wait == WW'(WAIT_MAX - 1)) r_timeout <= 1'b1;
        end
      end
      if (!w_init && StallF && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_br_flush && r_flush_cnt != '1)        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign mem_timeout  = r_timeout;
  assign stall_cycles = r_stall_cnt;
  assign flush_events = r_flush_cnt;

  forward_unit u_fwd_a (
    .i_rs         (Rs1E),
    .i_rd_m       (RdM),
    .i_rd_w       (RdW),
    .i_regwrite_m (RegWriteM),
    .i_regwrite_w (RegWriteW),
    .o_fwd        (ForwardAE)
  );

  forward_unit u_fwd_b (
    .i_rs         (Rs2E),
    .i_rd_m       (RdM),
    .i_rd_w       (RdW),
    .i_regwrite_m (RegWriteM),
    .i_regwrite_w (RegWriteW),
    .o_fwd        (ForwardBE)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mem_timeout;
  logic [15:0] stall_cycles, flush_events;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [3:0]  st;    // {StallM,StallE,StallD,StallF}
    logic [1:0]  fl;    // {FlushE,FlushD}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        chk;   // also check counters and timeout flag
    logic [15:0] sc;
    logic [15:0] fe;
    logic        to;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.INIT_BUBBLES(4), .WAIT_MAX(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [3:0] st;
      logic [1:0] fl;
      logic bad;
      e  = q.pop_front();
      st = {StallM, StallE, StallD, StallF};
      fl = {FlushE, FlushD};
      bad = (st !== e.st) || (fl !== e.fl) || (ForwardAE !== e.fa) || (ForwardBE !== e.fb);
      if (e.chk)
        bad = bad || (stall_cycles !== e.sc) || (flush_events !== e.fe) || (mem_timeout !== e.to);
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s: got st=%b fl=%b fa=%b fb=%b sc=%0d fe=%0d to=%b, want st=%b fl=%b fa=%b fb=%b sc=%0d fe=%0d to=%b (cnt checked=%b)",
                 e.name, st, fl, ForwardAE, ForwardBE, stall_cycles, flush_events, mem_timeout,
                 e.st, e.fl, e.fa, e.fb, e.sc, e.fe, e.to, e.chk);
      end
    end
  end

  task automatic defaults();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; MemReadyM = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string name, input logic [3:0] st, input logic [1:0] fl,
                          input logic [1:0] fa, input logic [1:0] fb, input logic chk,
                          input int sc, input int fe, input logic to);
    exp_t e;
    e.name = name; e.st = st; e.fl = fl; e.fa = fa; e.fb = fb;
    e.chk = chk; e.sc = 16'(sc); e.fe = 16'(fe); e.to = to;
    q.push_back(e);
    tick();
  endtask

  initial begin
    defaults();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Four INIT cycles; load-use and MemReadyM=0 are ignored there
    expect_v("init0", 4'b0001, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0);
    RdE = 5; ResultSrcE = 1; Rs1D = 5;
    expect_v("init1_lu", 4'b0001, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0);
    MemReadyM = 0;
    expect_v("init2_mem", 4'b0001, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0);
    MemReadyM = 1;
    expect_v("init3_lu", 4'b0001, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0);
    defaults();
    expect_v("run_idle", 4'b0000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);

    RdE = 5; ResultSrcE = 1; Rs1D = 5;
    expect_v("load_use", 4'b0011, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0);
    defaults();
    expect_v("lu_count", 4'b0000, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0);
    ResultSrcE = 1; RdE = 0; Rs1D = 0;
    expect_v("lu_rd0", 4'b0000, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0);
    RdE = 5; Rs2D = 5; PCSrcE = 1;
    expect_v("br_over_lu", 4'b0000, 2'b11, 2'b00, 2'b00, 1, 1, 0, 0);
    defaults();
    expect_v("br_count", 4'b0000, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0);

    RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; Rs2E = 7;
    expect_v("fwd_mem", 4'b0000, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0);
    RegWriteM = 0;
    expect_v("fwd_wb", 4'b0000, 2'b00, 2'b01, 2'b01, 0, 0, 0, 0);
    RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    expect_v("fwd_rd0", 4'b0000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    RdM = 7; Rs1E = 7; RdW = 3; Rs2E = 3;
    expect_v("fwd_mix", 4'b0000, 2'b00, 2'b10, 2'b01, 0, 0, 0, 0);

    // Memory wait with a held branch: stall all, flush on the ready cycle
    MemReadyM = 0; PCSrcE = 1;
    for (int unsigned i = 0; i < 3; i++)
      expect_v("memwait_br", 4'b1111, 2'b00, 2'b10, 2'b01, 1, 1 + int'(i), 1, 0);
    MemReadyM = 1;
    expect_v("memwait_rel", 4'b0000, 2'b11, 2'b10, 2'b01, 1, 4, 1, 0);
    defaults();
    expect_v("memwait_cnt", 4'b0000, 2'b00, 2'b00, 2'b00, 1, 4, 2, 0);

    MemReadyM = 0;
    for (int unsigned i = 0; i < 64; i++)
      expect_v("timeout_wait", 4'b1111, 2'b00, 2'b00, 2'b00, 1, 4 + int'(i), 2, 0);
    MemReadyM = 1;
    expect_v("timeout_set", 4'b0000, 2'b00, 2'b00, 2'b00, 1, 68, 2, 1);
    expect_v("timeout_sticky", 4'b0000, 2'b00, 2'b00, 2'b00, 1, 68, 2, 1);

    // Asynchronous reset in the middle of a memory wait
    MemReadyM = 0;
    expect_v("pre_rst_wait", 4'b1111, 2'b00, 2'b00, 2'b00, 1, 68, 2, 1);
    rst = 1'b1;
    expect_v("async_rst", 4'b0001, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0);
    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++)
      expect_v("reinit", 4'b0001, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0);
    MemReadyM = 1;
    expect_v("rerun", 4'b0000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
